// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_pkg
// Purpose  : Shared types and constants for the IFU/LSU memory arbiter.
//            Optional timeout feature macro: MEM_ARBITER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

  // Arbiter sequencing: idle (may issue) or waiting on the memory response
  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_t;

  // Which requester owns the outstanding memory transaction
  typedef enum logic [0:0] {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } arb_owner_t;

  // Read data returned to the owner when the memory never answers
  localparam logic [31:0] ARB_TIMEOUT_DATA = 32'hDEADBEEF;

endpackage
`default_nettype wire

// File: rtl/arb_req_slot.sv
`default_nettype none
// ============================================================================
// Module   : arb_req_slot
// Purpose  : Captures a one-cycle request pulse into a holding slot and keeps
//            it pending until the arbiter issues it (clear). A new pulse while
//            the slot is still pending is dropped.
// Revision : 1.0 - initial release
// ============================================================================
module arb_req_slot
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic                req_wen,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wmask,
  input  logic                clear,
  output logic                pend,
  output logic [ADDR_W-1:0]   addr,
  output logic                wen,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wmask
);

  // Capture the request fields on a pulse; pending drops when the slot is issued
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend  <= 1'b0;
      addr  <= '0;
      wen   <= 1'b0;
      wdata <= '0;
      wmask <= '0;
    end else begin
      if (clear) begin
        pend <= 1'b0;
      end
      // A pulse into an occupied slot is a protocol violation and is ignored
      if (req_valid && !pend) begin
        pend  <= 1'b1;
        addr  <= req_addr;
        wen   <= req_wen;
        wdata <= req_wdata;
        wmask <= req_wmask;
      end
    end
  end

  // Requesters must not pulse again until their previous request has issued
  a_no_double_request : assert property (
    @(posedge clock) disable iff (reset) !(req_valid && pend)
  );

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one memory port between the IFU (read-only) and the LSU
//            (read/write). Requests are held in per-requester slots, issued
//            one at a time with fixed LSU > IFU priority, and each response is
//            routed back to the requester that owns the transaction.
//            Optional macro MEM_ARBITER_TIMEOUT_EN adds a response timeout
//            with a timeout_err pulse.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clock,
  input  logic                reset,
  // IFU side
  input  logic                ifu_reqValid,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_respValid,
  output logic [DATA_W-1:0]   ifu_rdata,
  // LSU side
  input  logic                lsu_reqValid,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_respValid,
  output logic [DATA_W-1:0]   lsu_rdata,
  // Memory side
  output logic                mem_reqValid,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_respValid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
`ifdef MEM_ARBITER_TIMEOUT_EN
  ,
  output logic                timeout_err
`endif
);

  arb_state_t          state;
  arb_owner_t          owner;
  logic                cur_wen;

  logic                ifu_pend;
  logic [ADDR_W-1:0]   ifu_slot_addr;
  logic                ifu_slot_wen;
  logic [DATA_W-1:0]   ifu_slot_wdata;
  logic [DATA_W/8-1:0] ifu_slot_wmask;
  logic                lsu_pend;
  logic [ADDR_W-1:0]   lsu_slot_addr;
  logic                lsu_slot_wen;
  logic [DATA_W-1:0]   lsu_slot_wdata;
  logic [DATA_W/8-1:0] lsu_slot_wmask;

  logic                issue;
  logic                pick_lsu;
  logic                ifu_clear;
  logic                lsu_clear;
  logic                resp_fire;
  logic [DATA_W-1:0]   resp_data;
  logic                resp_timeout;

  // IFU never writes: its write fields are tied off at the slot input
  arb_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ifu_slot (
    .clock     (clock),
    .reset     (reset),
    .req_valid (ifu_reqValid),
    .req_addr  (ifu_addr),
    .req_wen   (1'b0),
    .req_wdata ({DATA_W{1'b0}}),
    .req_wmask ({(DATA_W/8){1'b0}}),
    .clear     (ifu_clear),
    .pend      (ifu_pend),
    .addr      (ifu_slot_addr),
    .wen       (ifu_slot_wen),
    .wdata     (ifu_slot_wdata),
    .wmask     (ifu_slot_wmask)
  );

  arb_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_lsu_slot (
    .clock     (clock),
    .reset     (reset),
    .req_valid (lsu_reqValid),
    .req_addr  (lsu_addr),
    .req_wen   (lsu_wen),
    .req_wdata (lsu_wdata),
    .req_wmask (lsu_wmask),
    .clear     (lsu_clear),
    .pend      (lsu_pend),
    .addr      (lsu_slot_addr),
    .wen       (lsu_slot_wen),
    .wdata     (lsu_slot_wdata),
    .wmask     (lsu_slot_wmask)
  );

  // Issue decision: fixed LSU-over-IFU priority, memory request driven straight from the slot
  always_comb begin
    issue     = (state == ARB_IDLE) && (ifu_pend || lsu_pend);
    pick_lsu  = lsu_pend;
    lsu_clear = issue && pick_lsu;
    ifu_clear = issue && !pick_lsu;

    mem_reqValid = issue;
    mem_addr     = '0;
    mem_wen      = 1'b0;
    mem_wdata    = '0;
    mem_wmask    = '0;
    if (lsu_clear) begin
      mem_addr  = lsu_slot_addr;
      mem_wen   = lsu_slot_wen;
      mem_wdata = lsu_slot_wdata;
      mem_wmask = lsu_slot_wmask;
    end else if (ifu_clear) begin
      mem_addr  = ifu_slot_addr;
      mem_wen   = ifu_slot_wen;
      mem_wdata = ifu_slot_wdata;
      mem_wmask = ifu_slot_wmask;
    end

    busy = (state == ARB_WAIT) || ifu_pend || lsu_pend;
  end

`ifdef MEM_ARBITER_TIMEOUT_EN
  // Counter is 0 on the first WAIT cycle; firing at TIMEOUT_CYCLES-2 puts the
  // owner's response pulse exactly TIMEOUT_CYCLES cycles after the issue cycle.
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

  logic [CNT_W-1:0] wait_cnt;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  // Completion of the outstanding transaction: real response or timeout
  always_comb begin
    resp_fire    = (state == ARB_WAIT) && mem_respValid;
    resp_data    = cur_wen ? '0 : mem_rdata;
    resp_timeout = 1'b0;
`ifdef MEM_ARBITER_TIMEOUT_EN
    if ((state == ARB_WAIT) && !mem_respValid && (wait_cnt == CNT_LAST)) begin
      resp_fire    = 1'b1;
      resp_data    = DATA_W'(ARB_TIMEOUT_DATA);
      resp_timeout = 1'b1;
    end
`endif
  end

  // Arbiter FSM with registered response pulses and read data to each requester
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ARB_IDLE;
      owner         <= OWN_IFU;
      cur_wen       <= 1'b0;
      ifu_respValid <= 1'b0;
      lsu_respValid <= 1'b0;
      ifu_rdata     <= '0;
      lsu_rdata     <= '0;
`ifdef MEM_ARBITER_TIMEOUT_EN
      wait_cnt      <= '0;
      timeout_err   <= 1'b0;
`endif
    end else begin
      ifu_respValid <= 1'b0;
      lsu_respValid <= 1'b0;
`ifdef MEM_ARBITER_TIMEOUT_EN
      timeout_err   <= 1'b0;
`endif
      case (state)
        ARB_IDLE: begin
          // Responses arriving here are stale and deliberately ignored
          if (issue) begin
            owner   <= pick_lsu ? OWN_LSU : OWN_IFU;
            cur_wen <= pick_lsu ? lsu_slot_wen : 1'b0;
            state   <= ARB_WAIT;
`ifdef MEM_ARBITER_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        ARB_WAIT: begin
          if (resp_fire) begin
            if (owner == OWN_LSU) begin
              lsu_respValid <= 1'b1;
              lsu_rdata     <= resp_data;
            end else begin
              ifu_respValid <= 1'b1;
              ifu_rdata     <= resp_data;
            end
            state <= ARB_IDLE;
          end
`ifdef MEM_ARBITER_TIMEOUT_EN
          timeout_err <= resp_timeout;
          if (!resp_fire) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

`ifndef MEM_ARBITER_TIMEOUT_EN
  logic unused_resp_timeout;
  assign unused_resp_timeout = resp_timeout;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Scoreboard bench for mem_arbiter: directed scenarios followed by
//            random IFU/LSU traffic against a memory responder with random
//            latency. Also builds with MEM_ARBITER_TIMEOUT_EN (TIMEOUT_CYCLES=8).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clock;
  logic          reset;
  logic          ifu_reqValid;
  logic [AW-1:0] ifu_addr;
  logic          ifu_respValid;
  logic [DW-1:0] ifu_rdata;
  logic          lsu_reqValid;
  logic [AW-1:0] lsu_addr;
  logic          lsu_wen;
  logic [DW-1:0] lsu_wdata;
  logic [3:0]    lsu_wmask;
  logic          lsu_respValid;
  logic [DW-1:0] lsu_rdata;
  logic          mem_reqValid;
  logic [AW-1:0] mem_addr;
  logic          mem_wen;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wmask;
  logic          mem_respValid;
  logic [DW-1:0] mem_rdata;
  logic          busy;
`ifdef MEM_ARBITER_TIMEOUT_EN
  logic          timeout_err;
`endif

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clock         (clock),
    .reset         (reset),
    .ifu_reqValid  (ifu_reqValid),
    .ifu_addr      (ifu_addr),
    .ifu_respValid (ifu_respValid),
    .ifu_rdata     (ifu_rdata),
    .lsu_reqValid  (lsu_reqValid),
    .lsu_addr      (lsu_addr),
    .lsu_wen       (lsu_wen),
    .lsu_wdata     (lsu_wdata),
    .lsu_wmask     (lsu_wmask),
    .lsu_respValid (lsu_respValid),
    .lsu_rdata     (lsu_rdata),
    .mem_reqValid  (mem_reqValid),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_respValid (mem_respValid),
    .mem_rdata     (mem_rdata),
    .busy          (busy)
`ifdef MEM_ARBITER_TIMEOUT_EN
    ,
    .timeout_err   (timeout_err)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          cyc;
  } req_t;

  typedef struct {
    logic [31:0] data;
    logic        tmo;
  } exp_t;

  req_t pend_ifu[$];
  req_t pend_lsu[$];
  exp_t exp_ifu[$];
  exp_t exp_lsu[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int resp_count = 0;

  // Responder / model controls written only by the main sequence
  bit silent = 1'b0;
  int fixed_lat = 0;
  int stale_cyc = -1;

  // Model of the single outstanding transaction
  bit          inflight = 1'b0;
  bit          inflight_lsu = 1'b0;
  int          inflight_due = -1;
  logic [31:0] inflight_addr = '0;
  logic        inflight_wen = 1'b0;
  int          countdown = 0;

  // Memory contents seen by reads: a fixed function of the address
  function automatic logic [31:0] mem_value(input logic [31:0] a);
    return a ^ 32'h80000013;
  endfunction

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic take_resp(input bit is_lsu, input logic [31:0] data, input logic tmo);
    exp_t e;
    int   sz;
    sz = is_lsu ? exp_lsu.size() : exp_ifu.size();
    resp_count++;
    check_eq(is_lsu ? "lsu_resp_expected" : "ifu_resp_expected", 32'(sz), 32'd1);
    if (sz > 0) begin
      e = is_lsu ? exp_lsu.pop_front() : exp_ifu.pop_front();
      check_eq(is_lsu ? "lsu_rdata" : "ifu_rdata", data, e.data);
      check_eq("resp_owner", {31'd0, is_lsu}, {31'd0, inflight_lsu});
      check_eq("resp_latency", 32'(cyc), 32'(inflight_due));
`ifdef MEM_ARBITER_TIMEOUT_EN
      check_eq("timeout_err", {31'd0, tmo}, {31'd0, e.tmo});
`endif
    end
    inflight = 1'b0;
  endtask

  logic tmo_sig;
`ifdef MEM_ARBITER_TIMEOUT_EN
  assign tmo_sig = timeout_err;
`else
  assign tmo_sig = 1'b0;
`endif

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Monitor + memory responder: checks DUT outputs, then drives the memory side
  initial begin
    mem_respValid = 1'b0;
    mem_rdata     = '0;
    forever begin
      bit   lsu_ok;
      bit   ifu_ok;
      bit   take_l;
      req_t r;
      exp_t e;
      @(negedge clock);
      mem_respValid = 1'b0;
      if (reset) begin
        countdown = 0;
        inflight  = 1'b0;
      end else begin
        if (ifu_respValid) take_resp(1'b0, ifu_rdata, tmo_sig);
        if (lsu_respValid) take_resp(1'b1, lsu_rdata, tmo_sig);

        // Memory answers lat cycles after the issue cycle
        if (countdown > 0) begin
          countdown--;
          if (countdown == 0) begin
            mem_respValid = 1'b1;
            mem_rdata     = inflight_wen ? $urandom : mem_value(inflight_addr);
            inflight_due  = cyc + 1;
          end
        end
        if (cyc == stale_cyc) begin
          mem_respValid = 1'b1;
          mem_rdata     = 32'h12345678;
        end

        lsu_ok = (pend_lsu.size() > 0) && (pend_lsu[0].cyc < cyc);
        ifu_ok = (pend_ifu.size() > 0) && (pend_ifu[0].cyc < cyc);
        check_eq("busy", {31'd0, busy}, {31'd0, (inflight || lsu_ok || ifu_ok)});

        if (mem_reqValid) begin
          check_eq("issue_has_pending", {31'd0, (lsu_ok || ifu_ok)}, 32'd1);
          check_eq("issue_while_outstanding", {31'd0, inflight}, 32'd0);
          if (lsu_ok || ifu_ok) begin
            take_l = lsu_ok;
            r = take_l ? pend_lsu.pop_front() : pend_ifu.pop_front();
            check_eq("mem_owner_lsu", 32'(take_l), 32'(mem_wen | (mem_addr == r.addr && take_l)));
            check_eq("mem_addr", mem_addr, r.addr);
            check_eq("mem_wen", {31'd0, mem_wen}, {31'd0, r.wen});
            check_eq("mem_wmask", {28'd0, mem_wmask}, {28'd0, r.wmask});
            if (r.wen) check_eq("mem_wdata", mem_wdata, r.wdata);
            e.data        = r.wen ? 32'd0 : mem_value(r.addr);
            e.tmo         = 1'b0;
            inflight      = 1'b1;
            inflight_lsu  = take_l;
            inflight_addr = r.addr;
            inflight_wen  = r.wen;
            inflight_due  = -1;
            if (silent) begin
`ifdef MEM_ARBITER_TIMEOUT_EN
              e.data       = 32'hDEADBEEF;
              e.tmo        = 1'b1;
              inflight_due = cyc + TO;
`endif
            end else begin
              countdown = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
            end
            if (take_l) exp_lsu.push_back(e);
            else        exp_ifu.push_back(e);
          end
        end else if (!inflight && (lsu_ok || ifu_ok)) begin
          check_eq("missed_issue", {31'd0, mem_reqValid}, 32'd1);
        end
      end
    end
  end

  // Drive one cycle of request pulses (caller sits just after a rising edge)
  task automatic step(input bit di, input logic [31:0] ia,
                      input bit dl, input logic [31:0] la, input bit lw,
                      input logic [31:0] ld, input logic [3:0] lm);
    req_t r;
    ifu_reqValid = di;
    ifu_addr     = ia;
    lsu_reqValid = dl;
    lsu_addr     = la;
    lsu_wen      = lw;
    lsu_wdata    = ld;
    lsu_wmask    = lm;
    if (di) begin
      r.addr = ia; r.wen = 1'b0; r.wdata = '0; r.wmask = '0; r.cyc = cyc;
      pend_ifu.push_back(r);
    end
    if (dl) begin
      r.addr = la; r.wen = lw; r.wdata = ld; r.wmask = lm; r.cyc = cyc;
      pend_lsu.push_back(r);
    end
    @(posedge clock);
    #1;
    ifu_reqValid = 1'b0;
    lsu_reqValid = 1'b0;
  endtask

  task automatic drain(input int bound);
    int left;
    left = 1;
    for (int i = 0; i < bound; i++) begin
      @(posedge clock);
      left = pend_ifu.size() + pend_lsu.size() + exp_ifu.size() + exp_lsu.size();
      if (left == 0) break;
    end
    #1;
    check_eq("drain_outstanding", 32'(left), 32'd0);
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    pend_ifu.delete();
    pend_lsu.delete();
    exp_ifu.delete();
    exp_lsu.delete();
    repeat (n) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    bit seen;
    int rc;
    reset        = 1'b1;
    ifu_reqValid = 1'b0;
    ifu_addr     = '0;
    lsu_reqValid = 1'b0;
    lsu_addr     = '0;
    lsu_wen      = 1'b0;
    lsu_wdata    = '0;
    lsu_wmask    = '0;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_eq("rst_mem_reqValid", {31'd0, mem_reqValid}, 32'd0);
    check_eq("rst_ifu_respValid", {31'd0, ifu_respValid}, 32'd0);
    check_eq("rst_lsu_respValid", {31'd0, lsu_respValid}, 32'd0);
    check_eq("rst_ifu_rdata", ifu_rdata, 32'd0);
    check_eq("rst_lsu_rdata", lsu_rdata, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;

    // IFU read, memory answers 3 cycles after issue
    fixed_lat = 3;
    step(1'b1, 32'h80000000, 1'b0, '0, 1'b0, '0, '0);
    @(negedge clock);
    check_eq("ifu_issue_next_cycle", {31'd0, mem_reqValid}, 32'd1);
    check_eq("ifu_issue_addr", mem_addr, 32'h80000000);
    drain(30);
    check_eq("ifu_rdata_value", ifu_rdata, 32'h00000013);

    // LSU write: rdata 0, busy low once the response is out
    step(1'b0, '0, 1'b1, 32'h100, 1'b1, 32'hA5A5A5A5, 4'b0011);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (lsu_respValid) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("lsu_write_resp_seen", {31'd0, seen}, 32'd1);
    check_eq("lsu_write_rdata", lsu_rdata, 32'd0);
    check_eq("busy_after_write", {31'd0, busy}, 32'd0);
    @(posedge clock);
    #1;

    // Contention: same-cycle pulses, LSU first
    fixed_lat = 2;
    step(1'b1, 32'h80000040, 1'b1, 32'h200, 1'b0, '0, '0);
    @(negedge clock);
    check_eq("contention_issue", {31'd0, mem_reqValid}, 32'd1);
    check_eq("contention_lsu_first", mem_addr, 32'h200);
    drain(40);
    check_eq("contention_ifu_data", ifu_rdata, mem_value(32'h80000040));
    check_eq("contention_lsu_data", lsu_rdata, mem_value(32'h200));

    // LSU read queued while the IFU transaction waits
    fixed_lat = 4;
    step(1'b1, 32'h80000080, 1'b0, '0, 1'b0, '0, '0);
    step(1'b0, '0, 1'b1, 32'h300, 1'b0, '0, '0);
    drain(40);
    check_eq("queued_ifu_data", ifu_rdata, mem_value(32'h80000080));
    check_eq("queued_lsu_data", lsu_rdata, mem_value(32'h300));

    // Memory never answers, then reset mid-transaction and a stale response
    silent = 1'b1;
    step(1'b1, 32'h80000100, 1'b0, '0, 1'b0, '0, '0);
    repeat (20) @(posedge clock);
    #1;
`ifdef MEM_ARBITER_TIMEOUT_EN
    check_eq("timeout_returns_idle", {31'd0, busy}, 32'd0);
    check_eq("timeout_rdata", ifu_rdata, 32'hDEADBEEF);
`else
    check_eq("wait_holds_busy", {31'd0, busy}, 32'd1);
`endif
    silent = 1'b0;
    apply_reset(2);
    rc = resp_count;
    stale_cyc = cyc + 1;
    repeat (6) @(posedge clock);
    #1;
    check_eq("stale_no_resp", 32'(resp_count), 32'(rc));
    check_eq("stale_busy", {31'd0, busy}, 32'd0);
    fixed_lat = 1;
    step(1'b1, 32'h80000004, 1'b0, '0, 1'b0, '0, '0);
    drain(20);
    check_eq("fresh_ifu_data", ifu_rdata, mem_value(32'h80000004));

    // Random traffic
    fixed_lat = 0;
    for (int i = 0; i < 500; i++) begin
      bit can_i;
      bit can_l;
      bit di;
      bit dl;
      can_i = (pend_ifu.size() == 0) &&
              ((exp_ifu.size() == 0) || (exp_ifu.size() == 1 && ifu_respValid));
      can_l = (pend_lsu.size() == 0) &&
              ((exp_lsu.size() == 0) || (exp_lsu.size() == 1 && lsu_respValid));
      di = can_i && ($urandom_range(0, 2) == 0);
      dl = can_l && ($urandom_range(0, 2) == 0);
      step(di, $urandom, dl, $urandom, 1'($urandom_range(0, 1)), $urandom,
           4'($urandom_range(0, 15)));
    end
    drain(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global bound so the run always ends
  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout: simulation did not complete, limit %0d ns", 200000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
